psum_drain_controller: RTL and testbench

Read-side counterpart of the psum write controller. After a PE finishes accumulating, this block reads the accumulated psums out of the PE's psum scratchpad in address order. It streams them to the GLB/next-PE link over a valid/ready handshake, then signals completion so the writer side can clear and restart. A 2-entry internal buffer absorbs the scratchpad's 1-cycle read latency, so backpressure never loses data.

---
 rtl/eyeriss_pkg.sv | 21 ++
 rtl/psum_drain_controller_if.sv | 30 +++
 rtl/psum_drain_controller_skid_fifo.sv | 57 +++++
 rtl/psum_drain_controller.sv | 111 +++++++++++
 tb/tb_psum_drain_controller.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/eyeriss_pkg.sv
// Definitions shared by the psum write and drain controllers: state
// encoding, default geometry and the drain-length clamp.
package eyeriss_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 12;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    PSUM_IDLE  = 2'b00,
    PSUM_READ  = 2'b01,
    PSUM_FLUSH = 2'b10,
    PSUM_DONE  = 2'b11
  } psum_state_e;

  function automatic int unsigned clampCount(input int unsigned requested,
                                             input int unsigned limit);
    return (requested > limit) ? limit : requested;
  endfunction

endpackage

// File: rtl/psum_drain_controller_if.sv
// Handshake bundle between the drain controller, its scratchpad and the
// downstream link; the controller takes the slave view.
interface psum_drain_controller_if import eyeriss_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              drain_start;
  logic [ADDR_W:0]   num_psum;
  logic              spad_rd_en;
  logic [ADDR_W-1:0] spad_rd_addr;
  logic [DATA_W-1:0] spad_rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    output drain_start, num_psum, spad_rd_data, out_ready,
    input  spad_rd_en, spad_rd_addr, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    input  drain_start, num_psum, spad_rd_data, out_ready,
    output spad_rd_en, spad_rd_addr, out_data, out_valid, out_last, busy, done
  );

endinterface

// File: rtl/psum_drain_controller_skid_fifo.sv
// Two-entry FIFO that soaks up the scratchpad read latency so a stalled
// downstream never drops a psum already in flight.
module psum_skid_fifo import eyeriss_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        count_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              rdPtr_q;
  logic              wrPtr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rdPtr_q  <= 1'b0;
      wrPtr_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= wdata_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (pop_i) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);

endmodule

// File: rtl/psum_drain_controller.sv
// Streams N accumulated psums out of the PE scratchpad in address order over
// a valid/ready link, then pulses done so the writer side can restart.
module psum_drain_controller import eyeriss_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic                     clk,
  input logic                     rst,
  psum_drain_controller_if.slave  drainIf
);

  localparam int CNT_W = ADDR_W + 1;

  psum_state_e       state_q;
  logic [CNT_W-1:0]  nPsum_q;
  logic [CNT_W-1:0]  issueCnt_q;
  logic [CNT_W-1:0]  sendCnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inFlight_q;

  logic [CNT_W-1:0]  nClamped;
  logic [DATA_W-1:0] fifoData;
  logic [1:0]        fifoCount;
  logic              fifoEmpty;
  logic              fifoFull;
  logic              outValid;
  logic              handshake;
  logic [2:0]        credit;
  logic              rdEn;

  // A same-cycle pop frees a slot in time for the next capture, so it is
  // credited here; that keeps one psum per cycle with ready held high.
  always_comb begin
    nClamped  = CNT_W'(clampCount(32'(drainIf.num_psum), DEPTH));
    outValid  = !fifoEmpty;
    handshake = outValid && drainIf.out_ready;
    credit    = {1'b0, fifoCount} + {2'b00, inFlight_q} - {2'b00, handshake};
    rdEn      = (state_q == PSUM_READ) && (issueCnt_q != nPsum_q) &&
                (credit < 3'd2) && (!fifoFull || handshake);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PSUM_IDLE;
      nPsum_q    <= '0;
      issueCnt_q <= '0;
      sendCnt_q  <= '0;
      addr_q     <= '0;
      inFlight_q <= 1'b0;
    end else begin
      inFlight_q <= rdEn;
      if (handshake) begin
        sendCnt_q <= sendCnt_q + CNT_W'(1);
      end
      case (state_q)
        PSUM_IDLE: begin
          if (drainIf.drain_start) begin
            nPsum_q    <= nClamped;
            issueCnt_q <= '0;
            sendCnt_q  <= '0;
            addr_q     <= '0;
            state_q    <= (nClamped == '0) ? PSUM_DONE : PSUM_READ;
          end
        end
        PSUM_READ: begin
          if (rdEn) begin
            addr_q     <= addr_q + ADDR_W'(1);
            issueCnt_q <= issueCnt_q + CNT_W'(1);
            if (issueCnt_q == nPsum_q - CNT_W'(1)) begin
              state_q <= PSUM_FLUSH;
            end
          end
        end
        PSUM_FLUSH: begin
          if (handshake && (sendCnt_q == nPsum_q - CNT_W'(1))) begin
            state_q <= PSUM_DONE;
          end
        end
        PSUM_DONE: begin
          addr_q     <= '0;
          issueCnt_q <= '0;
          sendCnt_q  <= '0;
          state_q    <= PSUM_IDLE;
        end
        default: state_q <= PSUM_IDLE;
      endcase
    end
  end

  psum_skid_fifo #(.DATA_W(DATA_W)) skidFifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inFlight_q),
    .pop_i   (handshake),
    .wdata_i (drainIf.spad_rd_data),
    .rdata_o (fifoData),
    .count_o (fifoCount),
    .empty_o (fifoEmpty),
    .full_o  (fifoFull)
  );

  assign drainIf.spad_rd_en   = rdEn;
  assign drainIf.spad_rd_addr = addr_q;
  assign drainIf.out_data     = fifoData;
  assign drainIf.out_valid    = outValid;
  assign drainIf.out_last     = outValid && (sendCnt_q == nPsum_q - CNT_W'(1));
  assign drainIf.busy         = (state_q != PSUM_IDLE);
  assign drainIf.done         = (state_q == PSUM_DONE);

endmodule

// File: tb/tb_psum_drain_controller.sv
// Bench for psum_drain_controller: scratchpad model plus a queue-based
// reference of the expected psum stream, read credits and done timing.
module tb_psum_drain_controller;
  import eyeriss_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 12;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [DATA_W-1:0] spad [16];

  always #5 clk = ~clk;

  psum_drain_controller_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) drainIf ();

  psum_drain_controller #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .drainIf (drainIf)
  );

  // Scratchpad: data appears the cycle after the read strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) drainIf.spad_rd_data <= '0;
    else if (drainIf.spad_rd_en) drainIf.spad_rd_data <= spad[drainIf.spad_rd_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [ADDR_W:0] num,
                               input logic ready);
    @(negedge clk);
    drainIf.drain_start = start;
    drainIf.num_psum    = num;
    drainIf.out_ready   = ready;
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_rd_en"},  drainIf.spad_rd_en,   0);
    checkOutput({tag, "_addr"},   drainIf.spad_rd_addr, 0);
    checkOutput({tag, "_data"},   drainIf.out_data,     0);
    checkOutput({tag, "_valid"},  drainIf.out_valid,    0);
    checkOutput({tag, "_last"},   drainIf.out_last,     0);
    checkOutput({tag, "_busy"},   drainIf.busy,         0);
    checkOutput({tag, "_done"},   drainIf.done,         0);
  endtask

  // readyMode: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
  task automatic runDrain(input int num, input int readyMode, input bit pulseInFlush,
                          input int abortAfterHs, input bit incData);
    int n;
    int issued;
    int sent;
    int lag1;
    int lag2;
    int lastHsCyc;
    int doneCount;
    bit finished;
    bit pulsed;
    bit prevValid;
    bit prevReady;
    logic [DATA_W-1:0] prevData;
    logic [DATA_W-1:0] expected [$];
    n = (num > DEPTH) ? DEPTH : num;
    for (int i = 0; i < 16; i++) spad[i] = incData ? DATA_W'(16'h100 + i) : DATA_W'($urandom);
    expected.delete();
    for (int i = 0; i < n; i++) expected.push_back(spad[i]);
    issued = 0; sent = 0; lag1 = 0; lag2 = 0; lastHsCyc = -10; doneCount = 0;
    finished = 0; pulsed = 0; prevValid = 0; prevReady = 1; prevData = '0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      logic start;
      logic ready;
      bit   hs;
      bit   expDone;
      start = (cyc == 0);
      if (pulseInFlush && !pulsed && n > 0 && issued == n && sent < n) begin
        start  = 1'b1;
        pulsed = 1;
      end
      case (readyMode)
        0:       ready = 1'b1;
        1:       ready = ((cyc % 3) == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      applyStimulus(start, (cyc == 0) ? (ADDR_W+1)'(num) : (ADDR_W+1)'(3), ready);
      hs = drainIf.out_valid && drainIf.out_ready;
      checkOutput("valid_model", drainIf.out_valid, lag2 > sent);
      if (prevValid && !prevReady) checkOutput("data_hold", drainIf.out_data, prevData);
      checkOutput("last", drainIf.out_last, drainIf.out_valid && (sent == n - 1));
      checkOutput("rd_en_rule", drainIf.spad_rd_en,
                  (cyc >= 1) && (issued < n) && ((issued - sent - int'(hs)) < 2));
      checkOutput("busy", drainIf.busy, (cyc >= 1) && (doneCount == 0));
      expDone = (n == 0) ? (cyc == 1) : ((sent == n) && (lastHsCyc == cyc - 1));
      checkOutput("done", drainIf.done, expDone);
      if (drainIf.spad_rd_en) begin
        checkOutput("rd_addr", drainIf.spad_rd_addr, issued);
        issued++;
      end
      if (hs) begin
        checkOutput("hs_in_range", sent < n, 1);
        if (sent < n) checkOutput("out_data", drainIf.out_data, expected[sent]);
        if (readyMode == 0) begin
          if (sent == 0) checkOutput("first_valid_cyc", cyc, 3);
          else checkOutput("back_to_back", cyc, lastHsCyc + 1);
        end
        lastHsCyc = cyc;
        sent++;
      end
      if (drainIf.done) begin
        doneCount++;
        finished = 1;
      end
      prevValid = drainIf.out_valid;
      prevReady = drainIf.out_ready;
      prevData  = drainIf.out_data;
      lag2 = lag1;
      lag1 = issued;
      if (abortAfterHs > 0 && sent == abortAfterHs) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkIdleOutputs("async_rst");
        for (int k = 0; k < 2; k++) begin
          applyStimulus(0, 0, 1);
          checkOutput("rst_no_done", drainIf.done, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    checkOutput("drain_finished", finished, 1);
    checkOutput("done_count", doneCount, 1);
    checkOutput("sent_count", sent, n);
    checkOutput("read_count", issued, n);
    applyStimulus(0, 0, 1);
    checkOutput("post_busy", drainIf.busy, 0);
    checkOutput("post_done", drainIf.done, 0);
    checkOutput("post_valid", drainIf.out_valid, 0);
  endtask

  initial begin
    drainIf.drain_start = 1'b0;
    drainIf.num_psum    = '0;
    drainIf.out_ready   = 1'b0;
    for (int i = 0; i < 16; i++) spad[i] = '0;
    @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    applyStimulus(0, 0, 1);

    $display("[TB] streaming 4 psums with ready held high");
    runDrain(4, 0, 0, 0, 1);
    $display("[TB] 6 psums under 1,0,0 backpressure");
    runDrain(6, 1, 0, 0, 0);
    $display("[TB] empty drain");
    runDrain(0, 0, 0, 0, 0);
    $display("[TB] oversize request clamps to depth");
    runDrain(15, 0, 0, 0, 1);
    $display("[TB] drain_start during flush is ignored");
    runDrain(6, 2, 1, 0, 0);
    runDrain(3, 0, 0, 0, 0);
    $display("[TB] reset mid-drain then fresh drain");
    runDrain(8, 0, 0, 2, 0);
    runDrain(5, 2, 0, 0, 0);
    $display("[TB] randomized drains");
    for (int r = 0; r < 6; r++) runDrain(int'($urandom_range(0, 15)), 2, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
